// File: rtl/wash_cycle_pkg.sv
// Shared encodings, price table and phase duration tables
// for the wash-cycle sequencer.
package wash_cycle_pkg;

    typedef enum logic [1:0] {
        MODE_SPIN   = 2'd0,
        MODE_SMALL  = 2'd1,
        MODE_MEDIUM = 2'd2,
        MODE_LARGE  = 2'd3
    } mode_e;

    // State value doubles as the phase code shown on the panel.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WASH   = 3'd1;
    localparam logic [2:0] ST_RINSE  = 3'd2;
    localparam logic [2:0] ST_SPIN   = 3'd3;
    localparam logic [2:0] ST_PAUSED = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int MAX_KG_DEF = 20;

    localparam logic signed [11:0] BASE_PRICE [4] =
        '{12'sd5, 12'sd10, 12'sd15, 12'sd20};

    localparam logic [9:0] WASH_S  [4] = '{10'd0,  10'd30, 10'd45, 10'd60};
    localparam logic [9:0] RINSE_S [4] = '{10'd0,  10'd20, 10'd30, 10'd40};
    localparam logic [9:0] SPIN_S  [4] = '{10'd20, 10'd15, 10'd20, 10'd30};

    function automatic logic [9:0] dur_of(input logic [1:0] m,
                                          input logic [2:0] st);
        dur_of = '0;
        case (st)
            ST_WASH:  dur_of = WASH_S[m];
            ST_RINSE: dur_of = RINSE_S[m];
            ST_SPIN:  dur_of = SPIN_S[m];
            default:  dur_of = '0;
        endcase
    endfunction

    // First phase after cur with a non-zero duration; spin is never empty.
    function automatic logic [2:0] next_run(input logic [1:0] m,
                                            input logic [2:0] cur);
        if (cur < ST_WASH && WASH_S[m] != 10'd0)
            next_run = ST_WASH;
        else if (cur < ST_RINSE && RINSE_S[m] != 10'd0)
            next_run = ST_RINSE;
        else if (cur < ST_SPIN)
            next_run = ST_SPIN;
        else
            next_run = ST_DONE;
    endfunction

endpackage

// File: rtl/wash_cycle_if.sv
// Setup-stage to wash-cycle bus: request, controls and
// status/display outputs.
interface wash_cycle_if;
    logic               start;
    logic [1:0]         mode;
    logic [4:0]         weight;
    logic signed [11:0] bal_in;
    logic               pause_btn;
    logic               abort;
    logic               busy;
    logic [2:0]         phase;
    logic signed [11:0] bal_out;
    logic               bal_we;
    logic               reject;
    logic [3:0]         d0;
    logic [3:0]         d1;
    logic [3:0]         d2;
    logic               lid_lock;
    logic               alarm;

    modport master (
        output start, mode, weight, bal_in, pause_btn, abort,
        input  busy, phase, bal_out, bal_we, reject,
        input  d0, d1, d2, lid_lock, alarm
    );

    modport slave (
        input  start, mode, weight, bal_in, pause_btn, abort,
        output busy, phase, bal_out, bal_we, reject,
        output d0, d1, d2, lid_lock, alarm
    );
endinterface

// File: rtl/wash_tick_gen.sv
// 1 s tick divider: freezes while en is low, clr restarts
// the count at zero.
module wash_tick_gen #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/wash_cycle.sv
// Wash-cycle sequencer: price check/charge, wash/rinse/spin timing.
// Define WASH_CYCLE_ALARM_EN to build the end-of-cycle alarm.
module wash_cycle
    import wash_cycle_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int MAX_KG      = MAX_KG_DEF,
    parameter int ALARM_S     = 3
) (
    input logic        clk,
    input logic        rst,
    wash_cycle_if.slave bus
);
    logic [2:0]         st, st_n, sav, sav_n;
    logic [9:0]         rem, rem_n, shown;
    mode_e              mode_r;
    logic               tick, enter, accept, refuse, run, done_exit;
    logic signed [11:0] price, bal_q;
    logic               we_q, rej_q, bad;

    assign price = BASE_PRICE[bus.mode] + $signed({7'd0, bus.weight});
    assign bad   = (bus.weight == 5'd0) || (32'(bus.weight) > MAX_KG)
                || (bus.bal_in < price);
    assign run   = st inside {ST_WASH, ST_RINSE, ST_SPIN};

    wash_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run || (st == ST_DONE && ALARM_S > 0)),
        .clr  (enter),
        .tick (tick)
    );

`ifdef WASH_CYCLE_ALARM_EN
    logic [7:0] acnt;
    logic       alarm_q;

    assign done_exit = tick && (acnt == 8'(ALARM_S - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acnt    <= '0;
            alarm_q <= 1'b0;
        end else if (st != ST_DONE && st_n == ST_DONE) begin
            acnt    <= '0;
            alarm_q <= 1'b1;
        end else if (st == ST_DONE && st_n == ST_DONE && tick) begin
            acnt    <= acnt + 8'd1;
            alarm_q <= ~alarm_q;
        end else if (st_n != ST_DONE) begin
            alarm_q <= 1'b0;
        end
    end

    assign bus.alarm = alarm_q;
`else
    assign done_exit = 1'b1;
    assign bus.alarm = 1'b0;
`endif

    always_comb begin
        st_n   = st;
        rem_n  = rem;
        sav_n  = sav;
        enter  = 1'b0;
        accept = 1'b0;
        refuse = 1'b0;
        case (st)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bad) begin
                        refuse = 1'b1;
                    end else begin
                        accept = 1'b1;
                        enter  = 1'b1;
                        st_n   = next_run(bus.mode, ST_IDLE);
                        rem_n  = dur_of(bus.mode, st_n);
                    end
                end
            end
            ST_WASH, ST_RINSE, ST_SPIN: begin
                if (bus.abort) begin
                    st_n  = ST_IDLE;
                    rem_n = '0;
                end else begin
                    if (tick) begin
                        if (rem <= 10'd1) begin
                            enter = 1'b1;
                            st_n  = next_run(mode_r, st);
                            rem_n = dur_of(mode_r, st_n);
                        end else begin
                            rem_n = rem - 10'd1;
                        end
                    end
                    // A press on the tick cycle pauses after the decrement.
                    if (bus.pause_btn && st_n != ST_DONE) begin
                        sav_n = st_n;
                        st_n  = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (bus.abort) begin
                    st_n  = ST_IDLE;
                    rem_n = '0;
                end else if (bus.pause_btn) begin
                    st_n = sav;
                end
            end
            ST_DONE: begin
                if (bus.abort || bus.start || done_exit)
                    st_n = ST_IDLE;
            end
            default: begin
                st_n  = ST_IDLE;
                rem_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= ST_IDLE;
            sav    <= ST_IDLE;
            rem    <= '0;
            mode_r <= MODE_SPIN;
            bal_q  <= '0;
            we_q   <= 1'b0;
            rej_q  <= 1'b0;
        end else begin
            st    <= st_n;
            sav   <= sav_n;
            rem   <= rem_n;
            we_q  <= accept;
            rej_q <= refuse;
            if (accept) begin
                bal_q  <= bus.bal_in - price;
                mode_r <= mode_e'(bus.mode);
            end
        end
    end

    assign shown        = (st == ST_IDLE) ? 10'd0 : rem;
    assign bus.d0       = 4'(shown % 10'd10);
    assign bus.d1       = 4'((shown / 10'd10) % 10'd10);
    assign bus.d2       = 4'(shown / 10'd100);
    assign bus.busy     = (st != ST_IDLE);
    assign bus.phase    = st;
    assign bus.lid_lock = run || (st == ST_PAUSED);
    assign bus.bal_out  = bal_q;
    assign bus.bal_we   = we_q;
    assign bus.reject   = rej_q;
endmodule

// File: tb/tb_wash_cycle.sv
// Randomized bench for wash_cycle against an elapsed-time
// model of the cycle built from the price and duration rules.
module tb_wash_cycle;
    localparam int T     = 10;
    localparam int MAXKG = 20;
    localparam int AS    = 3;
`ifdef WASH_CYCLE_ALARM_EN
    localparam bit ALM = 1'b1;
`else
    localparam bit ALM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    wash_cycle_if bus();

    wash_cycle #(
        .TICK_CYCLES (T),
        .MAX_KG      (MAXKG),
        .ALARM_S     (AS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int base_tab  [4] = '{5, 10, 15, 20};
    int wash_tab  [4] = '{0, 30, 45, 60};
    int rinse_tab [4] = '{0, 20, 30, 40};
    int spin_tab  [4] = '{20, 15, 20, 30};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected status e cycles after the start was accepted.
    function automatic void model(input int m, input int e,
                                  output int ph, output int rem,
                                  output int alm);
        int d[3];
        int acc;
        d[0] = wash_tab[m];
        d[1] = rinse_tab[m];
        d[2] = spin_tab[m];
        acc  = 0;
        ph   = 0;
        rem  = 0;
        alm  = 0;
        for (int i = 0; i < 3; i++) begin
            if (d[i] != 0) begin
                if (e < acc + d[i] * T) begin
                    ph  = i + 1;
                    rem = d[i] - (e - acc) / T;
                    return;
                end
                acc += d[i] * T;
            end
        end
        if (e < acc + (ALM ? AS * T : 1)) begin
            ph  = 5;
            alm = ALM ? int'(((e - acc) / T) % 2 == 0) : 0;
        end
    endfunction

    function automatic int run_len(input int m);
        return (wash_tab[m] + rinse_tab[m] + spin_tab[m]) * T;
    endfunction

    task automatic check_out(input string tag, input int ph,
                             input int rem, input int alm);
        int bcd;
        bcd = (rem / 100) * 256 + ((rem / 10) % 10) * 16 + rem % 10;
        chk({tag, ".phase"}, 32'(bus.phase), ph);
        chk({tag, ".bcd"}, {20'd0, bus.d2, bus.d1, bus.d0}, bcd);
        chk({tag, ".lid"}, 32'(bus.lid_lock), int'(ph >= 1 && ph <= 4));
        chk({tag, ".busy"}, 32'(bus.busy), int'(ph != 0));
        chk({tag, ".alarm"}, 32'(bus.alarm), alm);
    endtask

    // act: 0 run out, 1 pause/resume, 2 abort running, 3 abort paused
    task automatic run_txn(input string tag, input int m, input int w,
                           input int bal, input int act, input int at_in,
                           input int hold, input bit both);
        int price, ok, e, pleft, ph, rem, alm, at, r;
        bit did, fin;
        price = base_tab[m] + w;
        ok    = (w != 0 && w <= MAXKG && bal >= price);
        r     = run_len(m);
        at    = (at_in >= 0) ? at_in :
                int'($urandom_range(0, r - 2));
        bus.mode   = 2'(m);
        bus.weight = 5'(w);
        bus.bal_in = 12'(bal);
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, ".reject"}, 32'(bus.reject), int'(!ok));
        chk({tag, ".bal_we"}, 32'(bus.bal_we), ok);
        if (!ok) begin
            check_out({tag, ".refused"}, 0, 0, 0);
            @(posedge clk); #1;
            chk({tag, ".reject_pulse"}, 32'(bus.reject), 0);
            return;
        end
        chk({tag, ".bal_out"}, {{20{bus.bal_out[11]}}, bus.bal_out},
            bal - price);
        e     = 0;
        pleft = -1;
        did   = 1'b0;
        fin   = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            model(m, e, ph, rem, alm);
            if (pleft >= 0) ph = 4;
            check_out(tag, ph, rem, alm);
            if (cyc > 0) chk({tag, ".we_pulse"}, 32'(bus.bal_we), 0);
            if (ph == 0) begin
                fin = 1'b1;
                break;
            end
            if ((act == 2 && pleft < 0 && e == at) ||
                (act == 3 && pleft == 0)) begin
                bus.abort     = 1'b1;
                bus.pause_btn = both;
                @(posedge clk); #1;
                bus.abort     = 1'b0;
                bus.pause_btn = 1'b0;
                check_out({tag, ".abort"}, 0, 0, 0);
                fin = 1'b1;
                break;
            end
            if ((act == 1 || act == 3) && !did && e == at) begin
                bus.pause_btn = 1'b1;
                did   = 1'b1;
                pleft = hold;
                e++;
            end else if (pleft > 0) begin
                pleft--;
            end else if (pleft == 0) begin
                bus.pause_btn = 1'b1;
                pleft = -1;
            end else begin
                e++;
            end
            @(posedge clk); #1;
            bus.pause_btn = 1'b0;
        end
        if (!fin) chk({tag, ".timeout"}, 0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.mode      = 2'd0;
        bus.weight    = 5'd0;
        bus.bal_in    = 12'sd0;
        bus.pause_btn = 1'b0;
        bus.abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0);
        chk("reset.bal_out", 32'(bus.bal_out), 0);
        chk("reset.bal_we", 32'(bus.bal_we), 0);
        chk("reset.reject", 32'(bus.reject), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_txn("small", 1, 5, 100, 0, 0, 0, 1'b0);
        run_txn("large_poor", 3, 20, 39, 0, 0, 0, 1'b0);
        run_txn("spin_only", 0, 3, 8, 0, 0, 0, 1'b0);
        run_txn("zero_kg", 2, 0, 200, 0, 0, 0, 1'b0);
        run_txn("over_kg", 1, 21, 200, 0, 0, 0, 1'b0);
        run_txn("exact_bal", 3, 20, 40, 2, 5, 0, 1'b0);
        run_txn("neg_bal", 0, 1, -5, 0, 0, 0, 1'b0);
        run_txn("pause12", 2, 4, 50, 1, 33 * T - 1, 500, 1'b0);
        run_txn("abort_rinse", 1, 7, 60, 2, 350, 0, 1'b1);
        run_txn("abort_pause", 3, 9, 90, 3, 100, 20, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("rnd%0d", i),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 90)) - 10,
                    int'($urandom_range(0, 3)), -1,
                    int'($urandom_range(0, 200)),
                    1'($urandom_range(0, 1)));
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #0;
        end

        bus.mode   = 2'd1;
        bus.weight = 5'd5;
        bus.bal_in = 12'sd100;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0);
        chk("async_rst.bal_out", 32'(bus.bal_out), 0);
        @(negedge clk);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wash_cycle.md
# wash_cycle

Wash-cycle sequencer that sits directly downstream of the pre-wash setup stage. It accepts the setup stage's start pulse together with the chosen mode, load weight and current balance, then checks and charges the price. It runs the wash, rinse and spin phases against a 1 s tick, reports remaining time as BCD digits for the 4-digit scanner, and supports pause/resume, abort and an end-of-cycle alarm.

## Interface
Parameters:
- TICK_CYCLES, 100_000_000: clk cycles per 1 s tick; benches override to a small value.
- MAX_KG, 20: largest accepted weight in kg.
- ALARM_S, 3: alarm duration in ticks (only with alarm compiled in).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle request from the setup stage.
- mode, in, 2: 0 spin-only, 1 small, 2 medium, 3 large.
- weight, in, 5: load in kg, 0..31.
- bal_in, in, signed 12: current balance.
- pause_btn, in, 1: debounced one-cycle press.
- abort, in, 1: level; cancels the cycle.
- busy, out, 1: high in any state other than IDLE.
- phase, out, 3: 0 idle, 1 wash, 2 rinse, 3 spin, 4 paused, 5 done.
- bal_out, out, signed 12: new balance.
- bal_we, out, 1: one-cycle strobe; bal_out is valid while it is high.
- reject, out, 1: one-cycle pulse when a start is refused.
- d0, d1, d2, out, 4 each: BCD of remaining seconds in the current phase (ones, tens, hundreds).
- lid_lock, out, 1: high during wash, rinse, spin and paused.
- alarm, out, 1: buzzer drive.

## Operation
- Price equals BASE[mode] plus weight. BASE is 5, 10, 15, 20 for modes 0..3. The computation is 12-bit signed.
- Phase durations in ticks (wash/rinse/spin):
  - mode 0: 0/0/20.
  - mode 1: 30/20/15.
  - mode 2: 45/30/20.
  - mode 3: 60/40/30.
  - A phase with duration 0 is skipped.
- Start acceptance:
  - start in IDLE with weight > MAX_KG, weight==0, or bal_in < price → reject pulse; the block stays in IDLE.
  - Otherwise: bal_out = bal_in − price with a bal_we pulse, then the block enters the first non-zero phase.
- start is ignored outside IDLE.
- Phase sequence:
  - On entering a phase, the remaining count is loaded with that phase's duration.
  - Each tick decrements the count.
  - When the count reaches 0, the block advances to the next non-zero phase. After spin it goes to DONE.
- pause_btn:
  - In WASH, RINSE or SPIN → PAUSED. The tick divider and the remaining count freeze.
  - In PAUSED → returns to the saved phase, and the divider resumes from its frozen value.
  - Ignored in other states.
- abort takes the block from any running state (including PAUSED) to IDLE. There is no refund. lid_lock drops the next cycle.
- DONE: d2..d0 show 000. The block returns to IDLE on the next start, on abort, or after the alarm ends (immediately if the alarm is compiled out). A start arriving in DONE is not accepted until IDLE is reached.
- BCD digits are derived combinationally from the 10-bit remaining count (max 60) and are 000 in IDLE.

## Timing
- Reset values:
  - State IDLE, phase 0, busy 0.
  - bal_out 0, bal_we 0, reject 0.
  - d0, d1, d2 all 0.
  - lid_lock 0, alarm 0.
  - Divider and remaining count 0.
- Latency from start:
  - Cycle N: start is sampled.
  - Cycle N+1: bal_we/reject registered.
  - Cycle N+1: phase and lid_lock become valid.
- The tick divider restarts at 0 on each phase entry, so the first decrement lands TICK_CYCLES cycles after entry.
- Phase transition occurs on the same cycle the count reaches 0. A phase therefore lasts exactly duration × TICK_CYCLES cycles.
- Simultaneous events:
  - abort wins over pause_btn and over the tick.
  - pause_btn on the tick cycle: the decrement is applied, then the block pauses.
- Asynchronous rst mid-cycle returns to reset values. The charged balance is not restored.

## Configuration
- WASH_CYCLE_ALARM_EN defined: on entering DONE, alarm toggles every tick for ALARM_S ticks, then the block goes to IDLE.
- WASH_CYCLE_ALARM_EN undefined: alarm is tied to 0, and DONE lasts one cycle before IDLE.

## Structure
- Shared package holds:
  - Mode encodings.
  - State/phase encodings.
  - The BASE price table and duration tables.
  - MAX_KG default.
- One sub-module, wash_tick_gen: divider with enable (freeze), synchronous clear and a one-cycle tick output.
- BCD conversion stays inline.

## Test plan
- TICK_CYCLES=10, mode 1, weight 5, bal_in 100, start → bal_out 85 with bal_we on N+1. Phases run wash 300, rinse 200, spin 150 cycles, then DONE, then IDLE.
- mode 3, weight 20, bal_in 39, start → reject pulse, busy stays 0, no bal_we.
- mode 0, weight 3, bal_in 8 → bal_out 0, wash/rinse skipped, phase goes straight to 3, d1d0 = 20.
- Mode 2 wash at 12 remaining, pause_btn → phase 4, d1d0 holds 12 for 500 cycles. Second press → wash resumes, reaches 11 after 10 cycles.
- Rinse running, abort together with pause_btn → IDLE next cycle, lid_lock 0, digits 000.
- With WASH_CYCLE_ALARM_EN defined, ALARM_S=3: after spin, alarm toggles for 30 cycles, then IDLE. Without the macro, alarm stays 0.
